mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit -- byte/half/word load-store unit in front of a word-wide,
// little-endian data RAM of MEM_BYTES bytes.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 store, 0 load
//   req_size          00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned      zero-extend sub-word loads
//   req_addr/wdata    byte address, right-aligned store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores/errors), held
//   resp_err          misaligned / reserved size / out of range, held
//   ram_addr/rw/wdata registered word-aligned RAM command
//   ram_rdata         RAM read word, valid the edge after the read is issued
//
// Sub-word stores are read-modify-write: RD captures the word, the lane
// array below splices the new byte(s) in, WR writes the merged word back.

// One byte lane of the store merge.
module mem_access_lane (
  input  logic       be,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] out_byte
);
  assign out_byte = be ? new_byte : old_byte;
endmodule

module mem_access_unit #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ram_addr,
  output logic        ram_rw,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Only the fields still needed after accept are kept.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  addr_lo;
    logic [15:0] wdata;
    logic        err;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q;
  logic [31:0] word_q;

  // ---------------------------------------------------------------
  // Request decode (combinational on the live request bus)
  // ---------------------------------------------------------------
  logic [2:0]  req_bytes;
  logic [32:0] req_end;
  logic        req_err;
  logic        req_word_st;

  always_comb begin
    case (req_size)
      2'b00:   req_bytes = 3'd1;
      2'b01:   req_bytes = 3'd2;
      2'b10:   req_bytes = 3'd4;
      default: req_bytes = 3'd0;
    endcase
  end

  // 33-bit sum so an address near 2^32 cannot wrap back into range.
  assign req_end     = {1'b0, req_addr} + {30'd0, req_bytes};
  assign req_err     = (req_size == 2'b11)
                     | ((req_size == 2'b01) & req_addr[0])
                     | ((req_size == 2'b10) & (|req_addr[1:0]))
                     | (req_end > 33'(MEM_BYTES));
  assign req_word_st = req_we & (req_size == 2'b10);

  // ---------------------------------------------------------------
  // Store merge: lane enables + per-lane splice
  // ---------------------------------------------------------------
  logic [NUM_LANES-1:0]      lane_be;
  logic [NUM_LANES-1:0][7:0] lane_old, lane_new, lane_out;

  always_comb begin
    lane_be = '0;
    if (req_q.size == 2'b00) begin
      lane_be[req_q.addr_lo] = 1'b1;
    end else if (req_q.size == 2'b01) begin
      lane_be[{req_q.addr_lo[1], 1'b0}] = 1'b1;
      lane_be[{req_q.addr_lo[1], 1'b1}] = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_old[k] = ram_rdata[8*k +: 8];
    // Byte store feeds [7:0] to every lane; half store feeds [7:0] to the
    // even lane and [15:8] to the odd lane.
    assign lane_new[k] = (req_q.size == 2'b00) ? req_q.wdata[7:0]
                                               : req_q.wdata[8*(k%2) +: 8];
    mem_access_lane u_lane (
      .be       (lane_be[k]),
      .old_byte (lane_old[k]),
      .new_byte (lane_new[k]),
      .out_byte (lane_out[k])
    );
  end

  // ---------------------------------------------------------------
  // Load extract from the captured word
  // ---------------------------------------------------------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign ld_byte = word_q[{req_q.addr_lo, 3'b000} +: 8];
  assign ld_half = req_q.addr_lo[1] ? word_q[31:16] : word_q[15:0];

  always_comb begin
    case (req_q.size)
      2'b00:   ld_data = {{24{~req_q.uns & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~req_q.uns & ld_half[15]}}, ld_half};
      default: ld_data = word_q;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid) begin
                if (req_err)          state_nxt = S_RESP;
                else if (req_word_st) state_nxt = S_WR;
                else                  state_nxt = S_RD;
              end
      S_RD:   state_nxt = req_q.we ? S_WR : S_RESP;
      S_WR:   state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
  end

  // ---------------------------------------------------------------
  // Datapath / registered outputs
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      word_q     <= '0;
      ram_addr   <= '0;
      ram_rw     <= 1'b0;
      ram_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
                  req_q <= '{we: req_we, size: req_size, uns: req_unsigned,
                             addr_lo: req_addr[1:0], wdata: req_wdata[15:0],
                             err: req_err};
                  // Errored requests never touch the RAM port.
                  if (!req_err) begin
                    ram_addr <= {req_addr[31:2], 2'b00};
                    if (req_word_st) begin
                      ram_wdata <= req_wdata;
                      ram_rw    <= 1'b1;
                    end
                  end
                end
        S_RD:   begin
                  word_q <= ram_rdata;
                  if (req_q.we) begin
                    ram_wdata <= lane_out;
                    ram_rw    <= 1'b1;
                  end
                end
        S_WR:   ram_rw <= 1'b0;
        S_RESP: begin
                  resp_valid <= 1'b1;
                  resp_err   <= req_q.err;
                  resp_rdata <= (req_q.err | req_q.we) ? 32'd0 : ld_data;
                end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// random traffic, scored against a byte-array reference memory.
module tb_mem_access_unit;
  localparam int MEM_BYTES = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] ram_addr;
  logic        ram_rw;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_addr     (ram_addr),
    .ram_rw       (ram_rw),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  // Physical RAM seen by the DUT; preload port takes priority.
  logic [7:0] ram     [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];
  logic       pl_en = 1'b0;
  logic [5:0] pl_a  = 6'd0;
  logic [7:0] pl_d  = 8'd0;
  int         rw_cnt = 0;
  logic [5:0] ra;

  assign ra        = ram_addr[5:0];
  assign ram_rdata = (ram_addr < 32'd64) ?
                     {ram[ra + 6'd3], ram[ra + 6'd2], ram[ra + 6'd1], ram[ra]} : 32'd0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_a] <= pl_d;
    else if (ram_rw && ram_addr < 32'd64) begin
      ram[ra]        <= ram_wdata[7:0];
      ram[ra + 6'd1] <= ram_wdata[15:8];
      ram[ra + 6'd2] <= ram_wdata[23:16];
      ram[ra + 6'd3] <= ram_wdata[31:24];
    end
    if (ram_rw) rw_cnt <= rw_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic preload_byte(input int a, input logic [7:0] d);
    pl_en = 1'b1; pl_a = 6'(a); pl_d = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic preload_word(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) preload_byte(a + i, 8'(w >> (8*i)));
  endtask

  // Reference behaviour: plain byte-array semantics of a load/store.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] edata, output logic eerr,
                       output int elat, output int erw);
    int nb;
    longint unsigned a64;
    logic [31:0] v;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    a64 = {32'd0, addr};
    eerr = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
           (size == 2'd2 && addr[1:0] != 2'd0) || (a64 + longint'(nb) > MEM_BYTES);
    edata = 32'd0;
    erw   = 0;
    if (eerr) elat = 1;
    else if (!we) begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'(addr[5:0]) + i]) << (8*i));
      if (nb == 1 && !uns && v[7])  v = v | 32'hFFFF_FF00;
      if (nb == 2 && !uns && v[15]) v = v | 32'hFFFF_0000;
      edata = v;
      elat  = 2;
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[int'(addr[5:0]) + i] = 8'(wdata >> (8*i));
      elat = (nb == 4) ? 2 : 3;
      erw  = 1;
    end
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (resp_valid) break;
    end
  endtask

  task automatic run(input string tag, input logic we, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] edata, held;
    logic eerr;
    int elat, erw, lat, rw0;
    model(we, size, uns, addr, wdata, edata, eerr, elat, erw);
    @(negedge clk);
    chk({tag, "/ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    rw0 = rw_cnt;
    @(posedge clk); #1;
    // Scramble the bus while busy; results must not change.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    wait_resp(lat);
    chk({tag, "/lat"},   32'(lat), 32'(elat));
    chk({tag, "/rdata"}, resp_rdata, edata);
    chk({tag, "/err"},   32'(resp_err), 32'(eerr));
    chk({tag, "/rw"},    32'(rw_cnt - rw0), 32'(erw));
    held = resp_rdata;
    @(posedge clk); #1;
    chk({tag, "/pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, "/hold"},  resp_rdata, held);
  endtask

  logic [1:0]  esz [5] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd1};
  logic [31:0] ead [5] = '{32'd2, 32'd1, 32'd0, 32'd64, 32'd63};
  logic        ewe [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [31:0] ea, eb;
    logic eea, eeb;
    int la, lb, wa, wb, lat, rw0;
    logic seen;

    // Reset with random RAM contents.
    for (int i = 0; i < MEM_BYTES; i++) preload_byte(i, 8'($urandom));
    chk("rst/ready", 32'(req_ready), 32'd1);
    chk("rst/valid", 32'(resp_valid), 32'd0);
    chk("rst/err",   32'(resp_err), 32'd0);
    chk("rst/rdata", resp_rdata, 32'd0);
    chk("rst/raddr", ram_addr, 32'd0);
    chk("rst/rw",    32'(ram_rw), 32'd0);
    chk("rst/wdata", ram_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Word load.
    preload_word(8, 32'h1122_3344);
    run("lw8", 1'b0, 2'd2, 1'b0, 32'd8, 32'd0);
    chk("lw8/const", resp_rdata, 32'h1122_3344);

    // Sign/zero extension.
    preload_word(4, 32'h80FF_7F01);
    run("lb6", 1'b0, 2'd0, 1'b0, 32'd6, 32'd0);
    chk("lb6/const", resp_rdata, 32'hFFFF_FFFF);
    run("lbu6", 1'b0, 2'd0, 1'b1, 32'd6, 32'd0);
    chk("lbu6/const", resp_rdata, 32'h0000_00FF);
    run("lh6", 1'b0, 2'd1, 1'b0, 32'd6, 32'd0);
    chk("lh6/const", resp_rdata, 32'hFFFF_80FF);
    run("lhu4", 1'b0, 2'd1, 1'b1, 32'd4, 32'd0);
    chk("lhu4/const", resp_rdata, 32'h0000_7F01);

    // Sub-word store merges.
    preload_word(12, 32'hAABB_CCDD);
    run("sb13", 1'b1, 2'd0, 1'b0, 32'd13, 32'h0000_0012);
    chk("sb13/ram", {ram[15], ram[14], ram[13], ram[12]}, 32'hAABB_12DD);
    preload_word(12, 32'hAABB_CCDD);
    run("sh14", 1'b1, 2'd1, 1'b0, 32'd14, 32'h0000_5678);
    chk("sh14/ram", {ram[15], ram[14], ram[13], ram[12]}, 32'h5678_CCDD);

    // Error cases.
    for (int i = 0; i < 5; i++) begin
      run($sformatf("err%0d", i), ewe[i], esz[i], 1'b0, ead[i], 32'hFFFF_FFFF);
      chk($sformatf("err%0d/const", i), 32'(resp_err), 32'd1);
    end
    run("lb_wrap", 1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'd0);
    run("lw60", 1'b0, 2'd2, 1'b0, 32'd60, 32'd0);
    run("sb63", 1'b1, 2'd0, 1'b0, 32'd63, 32'h0000_00A5);
    run("sw60", 1'b1, 2'd2, 1'b0, 32'd60, 32'h0BAD_F00D);

    // Back-to-back with req_valid held: B waits for ready.
    model(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, ea, eea, la, wa);
    model(1'b0, 2'd0, 1'b1, 32'd6, 32'd0, eb, eeb, lb, wb);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'd8; req_wdata = 32'd0;
    @(posedge clk); #1;
    req_size = 2'd0; req_unsigned = 1'b1; req_addr = 32'd6; req_wdata = 32'hFFFF_FFFF;
    wait_resp(lat);
    chk("b2b_a/lat",   32'(lat), 32'(la));
    chk("b2b_a/rdata", resp_rdata, ea);
    chk("b2b_a/ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(lat);
    chk("b2b_b/lat",   32'(lat), 32'(lb));
    chk("b2b_b/rdata", resp_rdata, eb);

    // Reset during WR of a word store: write aborted, no response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'hDEAD_BEEF;
    rw0 = rw_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstwr/rw_on", 32'(ram_rw), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstwr/rw_off", 32'(ram_rw), 32'd0);
    chk("rstwr/ready",  32'(req_ready), 32'd1);
    chk("rstwr/valid",  32'(resp_valid), 32'd0);
    chk("rstwr/rdata",  resp_rdata, 32'd0);
    chk("rstwr/raddr",  ram_addr, 32'd0);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | resp_valid;
    end
    chk("rstwr/noresp", 32'(seen), 32'd0);
    chk("rstwr/nowrite", 32'(rw_cnt - rw0), 32'd0);
    chk("rstwr/ram0", {ram[3], ram[2], ram[1], ram[0]},
        {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]});

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      run($sformatf("rnd%0d", n), 1'($urandom), 2'($urandom_range(0, 3)),
          1'($urandom), 32'($urandom_range(0, 70)), $urandom);
    end

    // Final RAM image versus the reference memory.
    for (int i = 0; i < MEM_BYTES; i++)
      chk($sformatf("ram[%0d]", i), 32'(ram[i]), 32'(ref_mem[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
